// File: rtl/ram_scan_controller_pkg.sv
// Shared state encoding, defaults and the address-step helper for the
// RAM scan controller.
package ram_scan_controller_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam int          DB_CYCLES_DEF = 500000;
  localparam int          TIMEOUT_DEF   = 15;
  localparam logic [15:0] ERR_WORD_DEF  = 16'hDEAD;
  localparam logic [15:0] ADDR_MAX_DEF  = 16'hFFFF;

  // Wrapping single step, up or down, over the range 0..amax.
  function automatic logic [15:0] step_addr(input logic [15:0] a,
                                            input logic        up,
                                            input logic [15:0] amax);
    if (up) begin
      return (a == amax) ? 16'd0 : a + 16'd1;
    end
    return (a == 16'd0) ? amax : a - 16'd1;
  endfunction

endpackage

// File: rtl/ram_scan_controller_if.sv
// Request/acknowledge read bus between the scan controller and the
// word-addressed memory.
interface ram_scan_controller_if;

  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_ack;
  logic [15:0] mem_rd_data;

  modport master (
    output mem_rd_req,
    output mem_addr,
    input  mem_rd_ack,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_req,
    input  mem_addr,
    output mem_rd_ack,
    output mem_rd_data
  );

endinterface

// File: rtl/btn_debounce_oneshot.sv
// Two-flop synchroniser, level debouncer and rising-edge one-shot for a
// single raw push-button.
module btn_debounce_oneshot
  import ram_scan_controller_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_q <= r_level;
      // Any return to the accepted level restarts the stability window.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_level & ~r_level_q;

endmodule

// File: rtl/ram_scan_controller.sv
// Button-driven address stepper that reads one memory word per address
// and holds address/data for the 7-segment display controller.
module ram_scan_controller
  import ram_scan_controller_pkg::*;
#(
  parameter int          DB_CYCLES = DB_CYCLES_DEF,
  parameter logic [15:0] ADDR_MAX  = ADDR_MAX_DEF,
  parameter int          TIMEOUT   = TIMEOUT_DEF,
  parameter logic [15:0] ERR_WORD  = ERR_WORD_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         btn_up,
  input  logic                         btn_down,
  ram_scan_controller_if.master        bus,
  output logic [15:0]                  addr,
  output logic [15:0]                  D_out,
  output logic                         busy,
  output logic                         rd_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    w_btn_raw;
  logic [1:0]    w_step;
  logic          w_up;
  logic          w_down;

  state_t        r_state;
  logic [15:0]   r_addr;
  logic [15:0]   r_dout;
  logic          r_req;
  logic          r_busy;
  logic          r_err;
  logic [TW-1:0] r_tmo;

  assign w_btn_raw = {btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce_oneshot #(
        .DB_CYCLES (DB_CYCLES)
      ) u_btn (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (w_btn_raw[gi]),
        .o_pulse (w_step[gi])
      );
    end
  endgenerate

  assign w_up   = w_step[0];
  assign w_down = w_step[1];

  // Reset parks in FETCH with the request low, so the first clean cycle
  // launches the read of address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_addr  <= 16'd0;
      r_dout  <= 16'd0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_up ^ w_down) begin
            r_addr  <= step_addr(r_addr, w_up, ADDR_MAX);
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_req  <= 1'b1;
          r_busy <= 1'b1;
          if (r_req) begin
            if (bus.mem_rd_ack) begin
              r_dout  <= bus.mem_rd_data;
              r_err   <= 1'b0;
              r_req   <= 1'b0;
              r_tmo   <= '0;
              r_state <= ST_DONE;
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
              r_dout  <= ERR_WORD;
              r_err   <= 1'b1;
              r_req   <= 1'b0;
              r_tmo   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_tmo   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd_req = r_req;
  assign bus.mem_addr   = r_addr;
  assign addr           = r_addr;
  assign D_out          = r_dout;
  assign busy           = r_busy;
  assign rd_err         = r_err;

endmodule

// File: tb/tb_ram_scan_controller.sv
// Directed bench for ram_scan_controller: memory responder plus a read
// scoreboard that checks every completed read against queued expectations.
module tb_ram_scan_controller;

  localparam int DB = 4;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [15:0] addr;
  logic [15:0] D_out;
  logic        busy;
  logic        rd_err;

  int          n_pass = 0;
  int          n_total = 0;
  exp_t        exp_q[$];
  int          ack_delay = 2;
  logic [15:0] mem_data = 16'h0000;
  int          ack_cnt = 0;
  int          req_len = 0;
  int          last_req_len = 0;
  logic        prev_req = 1'b0;
  logic        prev_busy = 1'b0;

  ram_scan_controller_if bus ();

  ram_scan_controller #(
    .DB_CYCLES (DB),
    .ADDR_MAX  (16'hFFFF),
    .TIMEOUT   (15),
    .ERR_WORD  (16'hDEAD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .bus      (bus.master),
    .addr     (addr),
    .D_out    (D_out),
    .busy     (busy),
    .rd_err   (rd_err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
  endtask

  // Memory responder and read monitor, both evaluated on the falling edge.
  initial begin
    bus.mem_rd_ack  = 1'b0;
    bus.mem_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_req && !reset) begin
        ack_cnt++;
        bus.mem_rd_ack  = (ack_cnt == ack_delay);
        bus.mem_rd_data = (ack_cnt == ack_delay) ? mem_data : 16'($urandom);
      end else begin
        ack_cnt         = 0;
        bus.mem_rd_ack  = 1'b0;
        bus.mem_rd_data = 16'($urandom);
      end
      if (!reset) begin
        if (bus.mem_rd_req && !prev_req) begin
          check("rd_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("rd_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
          req_len = 0;
        end
        if (bus.mem_rd_req) req_len++;
        if (prev_busy && !busy) begin
          last_req_len = req_len;
          check("done_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("read done: addr=%h D_out=%h rd_err=%b (expected %h/%h/%b)",
                     addr, D_out, rd_err, e.addr, e.data, e.err);
            check("done_addr", 32'(addr), 32'(e.addr));
            check("done_data", 32'(D_out), 32'(e.data));
            check("done_err", 32'(rd_err), 32'(e.err));
          end
        end
      end
      prev_req  = bus.mem_rd_req;
      prev_busy = busy;
    end
  end

  task automatic expect_read(input logic [15:0] a, input logic [15:0] d, input logic e);
    exp_t x;
    x.addr = a;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic press(input logic up, input logic dn, input int hold);
    @(negedge clk);
    btn_up   = up;
    btn_down = dn;
    repeat (hold) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !bus.mem_rd_req) begin
        ok = 1'b1;
        break;
      end
    end
    check({"idle_", tag}, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_dout", 32'(D_out), 32'd0);
    check("rst_req", 32'(bus.mem_rd_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(rd_err), 32'd0);

    // Initial read of address 0
    mem_data  = 16'h1234;
    ack_delay = 2;
    expect_read(16'h0000, 16'h1234, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("req_after_reset", 32'(bus.mem_rd_req), 32'd1);
    check("addr_after_reset", 32'(bus.mem_addr), 32'd0);
    wait_idle("init");

    // Short glitch ignored, long hold yields exactly one step
    mem_data = 16'h5A01;
    expect_read(16'h0001, 16'h5A01, 1'b0);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    repeat (4) @(negedge clk);
    press(1'b1, 1'b0, 10);
    wait_idle("glitch_hold");
    check("addr_one", 32'(addr), 32'd1);

    // Wrap boundaries: 1 -> 0 -> FFFF -> 0 -> FFFF
    mem_data = 16'hC000;
    expect_read(16'h0000, 16'hC000, 1'b0);
    press(1'b0, 1'b1, 8);
    wait_idle("down_to_0");
    mem_data = 16'hCFFF;
    expect_read(16'hFFFF, 16'hCFFF, 1'b0);
    press(1'b0, 1'b1, 8);
    wait_idle("down_wrap");
    mem_data = 16'hA000;
    expect_read(16'h0000, 16'hA000, 1'b0);
    press(1'b1, 1'b0, 8);
    wait_idle("up_wrap");
    mem_data = 16'hAFFF;
    expect_read(16'hFFFF, 16'hAFFF, 1'b0);
    press(1'b0, 1'b1, 8);
    wait_idle("down_wrap2");

    // Timeout, then a good read clears the error
    ack_delay = -1;
    expect_read(16'h0000, 16'hDEAD, 1'b1);
    press(1'b1, 1'b0, 8);
    wait_idle("timeout");
    check("tmo_req_len", 32'(last_req_len), 32'd15);
    check("tmo_err", 32'(rd_err), 32'd1);
    check("tmo_req_low", 32'(bus.mem_rd_req), 32'd0);
    ack_delay = 1;
    mem_data  = 16'h0BB1;
    expect_read(16'h0001, 16'h0BB1, 1'b0);
    press(1'b1, 1'b0, 8);
    wait_idle("err_clear");

    // Simultaneous up/down: no step, no read
    press(1'b1, 1'b1, 8);
    wait_idle("both");
    check("both_addr", 32'(addr), 32'd1);

    // Second up press lands while the first read is still in FETCH
    ack_delay = 14;
    mem_data  = 16'h2222;
    expect_read(16'h0002, 16'h2222, 1'b0);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (7) @(negedge clk);
    btn_up = 1'b0;
    repeat (6) @(negedge clk);
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    btn_up = 1'b0;
    repeat (DB + 4) @(negedge clk);
    wait_idle("press_in_fetch");
    check("fetch_drop_addr", 32'(addr), 32'd2);

    // Reset mid-FETCH aborts, then re-reads address 0
    ack_delay = -1;
    expect_read(16'h0003, 16'hDEAD, 1'b1);
    @(negedge clk);
    btn_up = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.mem_rd_req) break;
    end
    check("midfetch_req_seen", 32'(bus.mem_rd_req), 32'd1);
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    btn_up = 1'b0;
    @(negedge clk);
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_dout", 32'(D_out), 32'd0);
    check("abort_req", 32'(bus.mem_rd_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    ack_delay = 3;
    mem_data  = 16'hBEEF;
    expect_read(16'h0000, 16'hBEEF, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reread_req", 32'(bus.mem_rd_req), 32'd1);
    check("reread_addr", 32'(bus.mem_addr), 32'd0);
    wait_idle("reread");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_scan_controller.md
Name: ram_scan_controller

Overview:
- Upstream feeder for the board's 7-segment display controller. It produces the 16-bit address and data words that the display controller shows.
- Debounces two raw push-buttons (step up / step down) and turns each press into a single address step.
- For each new address it performs a request/acknowledge read from a word-addressed memory, then holds the returned data for display.
- Sits between the board buttons plus memory on one side and the display controller on the other.

Parameters:
- DB_CYCLES, 500000, stable-input cycles required before a button level change is accepted (5 ms at 100 MHz).
- ADDR_MAX, 16'hFFFF, highest valid address; stepping wraps at this value.
- TIMEOUT, 15, cycles to wait for mem_rd_ack before aborting a read.
- ERR_WORD, 16'hDEAD, value loaded into D_out on a timed-out read.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_up  in  1  raw asynchronous "step up" button
- btn_down  in  1  raw asynchronous "step down" button
- mem_rd_ack  in  1  memory read acknowledge, one-cycle pulse
- mem_rd_data  in  16  memory read data, valid when mem_rd_ack=1
- mem_rd_req  out  1  memory read request
- mem_addr  out  16  memory read address
- addr  out  16  current address, goes to the display controller
- D_out  out  16  data at addr, goes to the display controller
- busy  out  1  high while a read is outstanding
- rd_err  out  1  sticky flag: last read timed out

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: addr=0, D_out=0, mem_rd_req=0, busy=0, rd_err=0.
  - Internal: synchronisers=0, debounced levels=0, debounce counters=0.
  - FSM state = FETCH. An initial read of address 0 is therefore issued on the first cycle after reset deasserts.
- Input conditioning, per button, identical logic:
  - 2-flop synchroniser feeding a debouncer.
  - Debouncer counter clears whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1 the debounced level takes the synchronised value and the counter clears.
  - Glitches shorter than DB_CYCLES are ignored.
- One-shot: each rising edge of a debounced level gives a 1-cycle step pulse (up_p / down_p). Holding a button yields exactly one step.
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - up_p alone: addr <= (addr==ADDR_MAX) ? 0 : addr+1; go to FETCH.
  - down_p alone: addr <= (addr==0) ? ADDR_MAX : addr-1; go to FETCH.
  - up_p and down_p in the same cycle: no change, stay in IDLE.
- FETCH:
  - mem_rd_req=1 and busy=1; mem_addr=addr, stable for the whole state.
  - Timeout counter increments every cycle.
  - mem_rd_ack=1: D_out <= mem_rd_data in that same cycle, rd_err <= 0, go to DONE.
  - Counter reaches TIMEOUT with no ack: D_out <= ERR_WORD, rd_err <= 1, go to DONE.
- DONE: mem_rd_req=0, busy=1 for exactly 1 cycle, then go to IDLE. Timeout counter clears.
- While in FETCH, addr already shows the new address and D_out still holds the previous data until the read completes.
- Step pulses arriving in FETCH or DONE are dropped, not queued.
- mem_rd_ack outside FETCH is ignored.
- Latency: a step pulse in IDLE cycle N gives addr updated at N+1 and mem_rd_req high at N+1. With ack in cycle N+1+k, D_out updates at N+2+k and IDLE is reached at N+3+k.
- Reset asserted during FETCH aborts the read: mem_rd_req=0 on the next edge, then a fresh read of address 0 is issued.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, FETCH=2'd1, DONE=2'd2).
  - ERR_WORD default.
  - Default DB_CYCLES and TIMEOUT values.
- One natural sub-module, btn_debounce_oneshot: synchroniser, debouncer and rising-edge pulse. It is instantiated twice, once per button.

Test Plan:
- Use DB_CYCLES=4 in simulation.
- Reset then idle; memory acks 2 cycles after req with data 16'h1234 → mem_rd_req rises the cycle after reset deasserts, mem_addr=0, D_out=16'h1234, addr=0, rd_err=0.
- btn_up held 10 cycles with a 2-cycle glitch first → exactly one step: addr=1, a single read of address 1, D_out = returned data; the glitch causes no step.
- addr=16'hFFFF, up press → addr=0. Then a down press → addr=16'hFFFF. A read is issued each time.
- Memory never acks → after TIMEOUT=15 cycles in FETCH: D_out=16'hDEAD, rd_err=1, mem_rd_req=0. The next successful read clears rd_err.
- Both buttons' debounced edges in the same cycle → addr unchanged, no read issued. An up press during FETCH → ignored, addr advances only once.
- Reset asserted mid-FETCH → next cycle addr=0, D_out=0, then a fresh read of address 0; ack data is captured correctly.
